// File: rtl/timer_pkg.sv
// Shared types and default sizes for the timing/utility library counters.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_PRESCALE_W = 4;

endpackage : timer_pkg

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle tick every divide+1 clocks while run is high.
// clear restarts the division phase and suppresses the tick for that cycle.
module tick_gen #(
  parameter int PRESCALE_W = timer_pkg::DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] divide,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // Tick when the phase counter reaches the divide setting; counter wraps to 0 there.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == divide) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + PRESCALE_W'(1);
      end
    end
  end

  // Phase counter register; holds while not running.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule : tick_gen

// File: rtl/down_timer.sv
// Loadable down-counter with prescaled tick, one-shot/periodic reload and
// a one-cycle expiry pulse when the count is consumed at zero.
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  periodic,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  expired
);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic                  expired_q, expired_d;
  logic [WIDTH-1:0]      ld_q, ld_d;
  logic                  per_q, per_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  start_acc;
  logic                  tick;

  // stop dominates start, so a simultaneous pair never restarts the prescaler
  assign start_acc = start && !stop;

  tick_gen #(.PRESCALE_W(PRESCALE_W)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_acc),
    .run    (state_q == RUN),
    .divide (pre_q),
    .tick   (tick)
  );

  // Next-state: stop > start > tick-driven count/expiry.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = 1'b0;
    ld_d      = ld_q;
    per_d     = per_q;
    pre_d     = pre_q;
    if (stop) begin
      // abort holds the count where it is; no expiry even if a tick lands here
      if (state_q == RUN) state_d = IDLE;
    end else if (start) begin
      state_d = RUN;
      count_d = load_val;
      ld_d    = load_val;
      per_d   = periodic;
      pre_d   = prescale;
    end else if (state_q == RUN && tick) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        // zero is terminal: reload or park at 0, never wrap
        expired_d = 1'b1;
        if (per_q) count_d = ld_q;
        else       state_d = IDLE;
      end
    end
  end

  // State, count, pulse and latched configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      expired_q <= 1'b0;
      ld_q      <= '0;
      per_q     <= 1'b0;
      pre_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      ld_q      <= ld_d;
      per_q     <= per_d;
      pre_q     <= pre_d;
    end
  end

  assign count   = count_q;
  assign busy    = (state_q == RUN);
  assign expired = expired_q;

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Directed bench for down_timer; cycle numbers count from the start strobe (cycle 0).
module tb_down_timer;

  logic       clk = 1'b0;
  logic       reset, start, stop, periodic;
  logic [7:0] load_val, count;
  logic [3:0] prescale;
  logic       busy, expired;

  int n_chk = 0;
  int n_err = 0;

  down_timer #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .load_val (load_val),
    .periodic (periodic),
    .prescale (prescale),
    .count    (count),
    .busy     (busy),
    .expired  (expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start strobe in cycle 0; returns positioned in cycle 1
  task automatic start_run(input logic [7:0] lv, input logic [3:0] ps, input logic per);
    load_val = lv; prescale = ps; periodic = per; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    int  cyc;
    bit  flag;
    logic [7:0] prev;

    reset = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0;
    load_val = '0; prescale = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_exp", expired, 0);

    // reset mid-run
    start_run(8'd10, 4'd0, 1'b0);
    step(); step(); step(); step();
    chk("mid_count_c5", count, 6);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_exp", expired, 0);

    // one-shot 3/0; config inputs wiggled after start must be ignored
    start_run(8'd3, 4'd0, 1'b0);
    load_val = 8'd99; prescale = 4'd7; periodic = 1'b1;
    chk("os_c1_count", count, 3);
    chk("os_c1_busy", busy, 1);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk("os_count", count, 4 - c);
      chk("os_exp_low", expired, 0);
    end
    step();
    chk("os_c5_exp", expired, 1);
    chk("os_c5_busy", busy, 0);
    chk("os_c5_count", count, 0);
    step();
    chk("os_c6_exp", expired, 0);
    chk("os_c6_count", count, 0);

    // one-shot 0/0: expiry on cycle 2
    start_run(8'd0, 4'd0, 1'b0);
    chk("z_c1_busy", busy, 1);
    chk("z_c1_exp", expired, 0);
    step();
    chk("z_c2_exp", expired, 1);
    chk("z_c2_busy", busy, 0);

    // periodic 2/1: period 6, pulses at cycles 7,13,19
    start_run(8'd2, 4'd1, 1'b1);
    for (int c = 2; c <= 19; c++) begin
      int p;
      step();
      p = (c - 1) % 6;
      chk("per_exp", expired, (p == 0) ? 1 : 0);
      chk("per_count", count, (p < 2) ? 2 : (p < 4) ? 1 : 0);
      chk("per_busy", busy, 1);
    end
    do_stop();
    chk("per_stop_count", count, 2);
    chk("per_stop_busy", busy, 0);
    chk("per_stop_exp", expired, 0);

    // abort 200/0 at cycle 50
    start_run(8'd200, 4'd0, 1'b0);
    flag = 1'b0;
    for (int c = 2; c <= 50; c++) begin
      step();
      if (expired) flag = 1'b1;
    end
    chk("ab_c50_count", count, 151);
    do_stop();
    chk("ab_count", count, 151);
    chk("ab_busy", busy, 0);
    for (int c = 0; c < 5; c++) begin
      step();
      if (expired) flag = 1'b1;
    end
    chk("ab_hold", count, 151);
    chk("ab_no_exp", flag, 0);
    stop = 1'b1; step(); stop = 1'b0;
    chk("idle_stop_count", count, 151);

    // restart mid-run clears prescaler
    start_run(8'd20, 4'd3, 1'b0);
    for (int c = 0; c < 10; c++) step();
    start_run(8'd5, 4'd3, 1'b0);
    chk("rs_count", count, 5);
    chk("rs_busy", busy, 1);
    step(); step(); step();
    chk("rs_c4_count", count, 5);
    step();
    chk("rs_c5_count", count, 4);

    // restart on a terminal tick: no expiry, new load taken
    do_stop();
    start_run(8'd0, 4'd0, 1'b0);
    start_run(8'd7, 4'd0, 1'b0);
    chk("rst_tick_exp", expired, 0);
    chk("rst_tick_count", count, 7);
    chk("rst_tick_busy", busy, 1);

    // start+stop together in RUN and in IDLE
    start_run(8'd50, 4'd0, 1'b0);
    step(); step();
    chk("ss_c3_count", count, 48);
    start = 1'b1; stop = 1'b1; load_val = 8'd9;
    step();
    start = 1'b0; stop = 1'b0;
    chk("ss_run_busy", busy, 0);
    chk("ss_run_count", count, 48);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("ss_idle_busy", busy, 0);
    chk("ss_idle_count", count, 48);

    // periodic 0/0: expired every cycle after the first RUN cycle
    start_run(8'd0, 4'd0, 1'b1);
    chk("pz_c1_exp", expired, 0);
    for (int c = 2; c <= 6; c++) begin
      step();
      chk("pz_exp", expired, 1);
      chk("pz_busy", busy, 1);
    end
    do_stop();

    // 255/15: expiry exactly 4096 clocks after cycle 1
    start_run(8'd255, 4'd15, 1'b0);
    cyc = 1; flag = 1'b0; prev = count;
    while (!expired && cyc < 5000) begin
      step();
      cyc++;
      if (count > prev) flag = 1'b1;
      prev = count;
    end
    chk("max_exp_cycle", cyc, 4097);
    chk("max_no_wrap", flag, 0);
    chk("max_count", count, 0);
    chk("max_busy", busy, 0);
    step();
    chk("max_exp_drop", expired, 0);
    chk("max_count_stay", count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_down_timer
